// File: rtl/cache_axi_pkg.sv
// Shared encodings and defaults for the cache-side AXI-style word responder.
package cache_axi_pkg;

    localparam int DEFAULT_DEPTH     = 1024;
    localparam int DEFAULT_READ_LAT  = 2;
    localparam int DEFAULT_WRITE_LAT = 1;
    localparam int LAT_W             = 8;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_WAIT = 1'b1
    } wr_state_e;

endpackage

// File: rtl/resp_lat_counter.sv
// Loadable down-counter; done_o marks the last waiting cycle before a response.
module resp_lat_counter
    import cache_axi_pkg::*;
#(
    parameter int W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         clear_i,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == W'(1));

endmodule

// File: rtl/cache_axi_responder.sv
// Word-addressed memory responder with independent read and write burst FSMs.
// state   | meaning
// *_IDLE  | no burst; accept a new one when ce & request & ready/valid
// *_WAIT  | burst active; latency countdown or waiting for the next beat
module cache_axi_responder
    import cache_axi_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int READ_LAT  = DEFAULT_READ_LAT,
    parameter int WRITE_LAT = DEFAULT_WRITE_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_ce_i,
    input  logic [3:0]  axi_sel_i,
    input  logic        axi_ren_i,
    input  logic        axi_rready_i,
    input  logic [31:0] axi_raddr_i,
    input  logic [3:0]  axi_rlen_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    input  logic        axi_wen_i,
    input  logic        axi_wvalid_i,
    input  logic        axi_wlast_i,
    input  logic [31:0] axi_waddr_i,
    input  logic [31:0] axi_wdata_i,
    input  logic [3:0]  axi_wlen_i,
    output logic        wdata_resp_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LAT - 1);
    localparam bit RD_FAST = (READ_LAT == 1);
    localparam bit WR_FAST = (WRITE_LAT == 1);

    logic [31:0] mem [DEPTH];

    rd_state_e          rd_state_q, rd_state_d;
    logic [4:0]         rd_cnt_q, rd_cnt_d;
    logic [3:0]         rd_len_q, rd_len_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic               rd_last_q, rd_last_d;
    logic               rd_samp_q, rd_samp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               rd_sample, rd_abort, rd_is_last, rd_fire, rd_fire_last, rd_ctr_done;
    logic [IDX_W-1:0]   rd_in_idx, rd_fire_idx;

    wr_state_e          wr_state_q, wr_state_d;
    logic [4:0]         wr_cnt_q, wr_cnt_d;
    logic [3:0]         wr_len_q, wr_len_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic [3:0]         wr_sel_q, wr_sel_d;
    logic               wr_last_q, wr_last_d;
    logic               wr_samp_q, wr_samp_d;
    logic               wresp_q, wresp_d;
    logic               err_q, err_d;
    logic               wr_sample, wr_abort, wr_is_last, wr_fire, wr_fire_last, wr_ctr_done;

    logic               unused_addr_bits;

    assign rd_in_idx = axi_raddr_i[IDX_W+1:2];
    assign unused_addr_bits = ^{axi_raddr_i[31:IDX_W+2], axi_raddr_i[1:0],
                                axi_waddr_i[31:IDX_W+2], axi_waddr_i[1:0]};

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_len_d     = rd_len_q;
        rd_idx_d     = rd_idx_q;
        rd_last_d    = rd_last_q;
        rd_samp_d    = rd_samp_q;
        rdata_d      = rdata_q;
        rd_sample    = 1'b0;
        rd_abort     = 1'b0;
        rd_is_last   = 1'b0;
        rd_fire      = 1'b0;
        rd_fire_last = 1'b0;
        rd_fire_idx  = rd_idx_q;
        case (rd_state_q)
            RD_IDLE: begin
                rd_sample  = axi_ce_i & axi_ren_i & axi_rready_i;
                rd_is_last = (axi_rlen_i == 4'd0);
                if (rd_sample) begin
                    rd_len_d   = axi_rlen_i;
                    rd_cnt_d   = 5'd1;
                    rd_state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rd_abort   = ~axi_ren_i;
                rd_sample  = rd_samp_q & axi_ren_i & axi_rready_i;
                rd_is_last = (rd_cnt_q == {1'b0, rd_len_q});
                if (rd_sample) begin
                    rd_cnt_d = rd_cnt_q + 5'd1;
                end
                // initiator advances its address during the pulse cycle
                if (rvalid_q) begin
                    rd_samp_d = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        if (rd_sample) begin
            rd_idx_d  = rd_in_idx;
            rd_last_d = rd_is_last;
            rd_samp_d = 1'b0;
        end
        if (RD_FAST && rd_sample) begin
            rd_fire      = 1'b1;
            rd_fire_last = rd_is_last;
            rd_fire_idx  = rd_in_idx;
        end else if (rd_state_q == RD_WAIT && rd_ctr_done) begin
            rd_fire      = 1'b1;
            rd_fire_last = rd_last_q;
        end
        if (rd_abort) begin
            rd_fire    = 1'b0;
            rd_state_d = RD_IDLE;
        end
        if (rd_fire) begin
            rdata_d = mem[rd_fire_idx];
            if (rd_fire_last) begin
                rd_state_d = RD_IDLE;
            end
        end
        if (rd_state_d == RD_IDLE) begin
            rd_samp_d = 1'b0;
        end
        rvalid_d = rd_fire;
    end

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_cnt_d     = wr_cnt_q;
        wr_len_d     = wr_len_q;
        wr_idx_d     = wr_idx_q;
        wr_data_d    = wr_data_q;
        wr_sel_d     = wr_sel_q;
        wr_last_d    = wr_last_q;
        wr_samp_d    = wr_samp_q;
        err_d        = err_q;
        wr_sample    = 1'b0;
        wr_abort     = 1'b0;
        wr_is_last   = 1'b0;
        wr_fire      = 1'b0;
        wr_fire_last = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                wr_sample  = axi_ce_i & axi_wen_i & axi_wvalid_i;
                wr_is_last = (axi_wlen_i == 4'd0);
                if (wr_sample) begin
                    wr_len_d   = axi_wlen_i;
                    wr_cnt_d   = 5'd1;
                    wr_state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                wr_abort   = ~axi_wen_i;
                wr_sample  = wr_samp_q & axi_wen_i & axi_wvalid_i;
                wr_is_last = (wr_cnt_q == {1'b0, wr_len_q});
                if (wr_sample) begin
                    wr_cnt_d = wr_cnt_q + 5'd1;
                end
                if (wresp_q) begin
                    wr_samp_d = 1'b1;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (wr_sample) begin
            wr_idx_d  = axi_waddr_i[IDX_W+1:2];
            wr_data_d = axi_wdata_i;
            wr_sel_d  = axi_sel_i;
            wr_last_d = wr_is_last;
            wr_samp_d = 1'b0;
            if (axi_wlast_i != wr_is_last) begin
                err_d = 1'b1;
            end
        end
        if (WR_FAST && wr_sample) begin
            wr_fire      = 1'b1;
            wr_fire_last = wr_is_last;
        end else if (wr_state_q == WR_WAIT && wr_ctr_done) begin
            wr_fire      = 1'b1;
            wr_fire_last = wr_last_q;
        end
        if (wr_abort) begin
            wr_fire    = 1'b0;
            wr_state_d = WR_IDLE;
        end
        if (wr_fire && wr_fire_last) begin
            wr_state_d = WR_IDLE;
        end
        if (wr_state_d == WR_IDLE) begin
            wr_samp_d = 1'b0;
        end
        wresp_d = wr_fire;
    end

    resp_lat_counter #(.W(LAT_W)) u_rd_lat (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rd_sample & ~RD_FAST),
        .load_val_i (RD_LOAD),
        .clear_i    (rd_abort),
        .done_o     (rd_ctr_done)
    );

    resp_lat_counter #(.W(LAT_W)) u_wr_lat (
        .clk        (clk),
        .rst        (rst),
        .load_i     (wr_sample & ~WR_FAST),
        .load_val_i (WR_LOAD),
        .clear_i    (wr_abort),
        .done_o     (wr_ctr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= RD_IDLE;
            rd_cnt_q   <= '0;
            rd_len_q   <= '0;
            rd_idx_q   <= '0;
            rd_last_q  <= 1'b0;
            rd_samp_q  <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
            wr_cnt_q   <= '0;
            wr_len_q   <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            wr_sel_q   <= '0;
            wr_last_q  <= 1'b0;
            wr_samp_q  <= 1'b0;
            wresp_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_len_q   <= rd_len_d;
            rd_idx_q   <= rd_idx_d;
            rd_last_q  <= rd_last_d;
            rd_samp_q  <= rd_samp_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_len_q   <= wr_len_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            wr_sel_q   <= wr_sel_d;
            wr_last_q  <= wr_last_d;
            wr_samp_q  <= wr_samp_d;
            wresp_q    <= wresp_d;
            err_q      <= err_d;
        end
    end

    // commit lands at the end of the response cycle so a same-cycle read sees old data
    always_ff @(posedge clk) begin
        if (wresp_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel_q[b]) begin
                    mem[wr_idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign wdata_resp_o  = wresp_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cache_axi_responder.sv
// Directed bench for cache_axi_responder: bursts, byte enables, wrap, hazards, errors, reset.
module tb_cache_axi_responder;

    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        axi_ce_i, axi_ren_i, axi_rready_i, axi_wen_i, axi_wvalid_i, axi_wlast_i;
    logic [3:0]  axi_sel_i, axi_rlen_i, axi_wlen_i;
    logic [31:0] axi_raddr_i, axi_waddr_i, axi_wdata_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, wdata_resp_o, err_o;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    cache_axi_responder #(.DEPTH(1024), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk           (clk),
        .rst           (rst),
        .axi_ce_i      (axi_ce_i),
        .axi_sel_i     (axi_sel_i),
        .axi_ren_i     (axi_ren_i),
        .axi_rready_i  (axi_rready_i),
        .axi_raddr_i   (axi_raddr_i),
        .axi_rlen_i    (axi_rlen_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .axi_wen_i     (axi_wen_i),
        .axi_wvalid_i  (axi_wvalid_i),
        .axi_wlast_i   (axi_wlast_i),
        .axi_waddr_i   (axi_waddr_i),
        .axi_wdata_i   (axi_wdata_i),
        .axi_wlen_i    (axi_wlen_i),
        .wdata_resp_o  (wdata_resp_o),
        .err_o         (err_o)
    );

    // Read initiator: advances address on every valid pulse, drops ren after the last one.
    task automatic drive_read(input logic [31:0] base, input logic [3:0] len,
                              output int np, output logic [31:0] dat [16], output int pc [16]);
        int cyc, beat, tail;
        np = 0; beat = 0; cyc = 0; tail = 0;
        for (int i = 0; i < 16; i++) begin dat[i] = '0; pc[i] = -1; end
        axi_raddr_i = base; axi_rlen_i = len;
        axi_ren_i = 1'b1; axi_rready_i = 1'b1; axi_ce_i = 1'b1;
        while (tail < 6 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            axi_ce_i = 1'b0;
            if (rdata_valid_o) begin
                if (np < 16) begin dat[np] = rdata_o; pc[np] = cyc; end
                np++; beat++;
                axi_raddr_i = base + 32'(4 * beat);
                if (beat == int'(len) + 1) axi_ren_i = 1'b0;
            end
            if (!axi_ren_i) tail++;
        end
        axi_ren_i = 1'b0; axi_rready_i = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] base, input logic [3:0] len,
                               input logic [31:0] d0, input logic [3:0] sel, input int bad_beat,
                               output int np, output int pc [16], output logic ev [16]);
        int cyc, beat, tail;
        np = 0; beat = 0; cyc = 0; tail = 0;
        for (int i = 0; i < 16; i++) begin pc[i] = -1; ev[i] = 1'b0; end
        axi_waddr_i = base; axi_wdata_i = d0; axi_sel_i = sel; axi_wlen_i = len;
        axi_wlast_i = (len == 4'd0) || (bad_beat == 0);
        axi_wen_i = 1'b1; axi_wvalid_i = 1'b1; axi_ce_i = 1'b1;
        while (tail < 6 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            axi_ce_i = 1'b0;
            if (wdata_resp_o) begin
                if (np < 16) begin pc[np] = cyc; ev[np] = err_o; end
                np++; beat++;
                axi_waddr_i = base + 32'(4 * beat);
                axi_wdata_i = d0 + 32'(beat);
                axi_wlast_i = (beat == int'(len)) || (beat == bad_beat);
                if (beat == int'(len) + 1) begin axi_wen_i = 1'b0; axi_wvalid_i = 1'b0; end
            end
            if (!axi_wen_i) tail++;
        end
        axi_wen_i = 1'b0; axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        axi_ce_i = 0; axi_sel_i = 0; axi_ren_i = 0; axi_rready_i = 0; axi_raddr_i = 0; axi_rlen_i = 0;
        axi_wen_i = 0; axi_wvalid_i = 0; axi_wlast_i = 0; axi_waddr_i = 0; axi_wdata_i = 0; axi_wlen_i = 0;
        repeat (3) @(posedge clk);
        #1;
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
        vecs++; if (rdata_valid_o !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b expected 0", rdata_valid_o); end
        vecs++; if (wdata_resp_o !== 1'b0) begin errs++; $display("FAIL reset_wresp: got %b expected 0", wdata_resp_o); end
        vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", err_o); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_burst();
        int np; int pc [16]; logic ev [16];
        drive_write(32'h100, 4'd7, 32'hA0, 4'hF, -1, np, pc, ev);
        vecs++; if (np !== 8) begin errs++; $display("FAIL wburst_count: got %0d expected 8", np); end
        for (int k = 0; k < 8; k++) begin
            vecs++;
            if (pc[k] !== k * (WL + 1) + WL) begin
                errs++; $display("FAIL wburst_timing beat %0d: got cycle %0d expected %0d", k, pc[k], k * (WL + 1) + WL);
            end
        end
        vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL wburst_err: got %b expected 0", err_o); end
    endtask

    task automatic test_read_burst();
        int np; logic [31:0] dat [16]; int pc [16];
        drive_read(32'h100, 4'd7, np, dat, pc);
        vecs++; if (np !== 8) begin errs++; $display("FAIL rburst_count: got %0d expected 8", np); end
        for (int k = 0; k < 8; k++) begin
            vecs++;
            if (dat[k] !== 32'hA0 + 32'(k)) begin
                errs++; $display("FAIL rburst_data beat %0d: got %h expected %h", k, dat[k], 32'hA0 + 32'(k));
            end
            vecs++;
            if (pc[k] !== k * (RL + 1) + RL) begin
                errs++; $display("FAIL rburst_timing beat %0d: got cycle %0d expected %0d", k, pc[k], k * (RL + 1) + RL);
            end
        end
    endtask

    task automatic test_byte_enable();
        int np; int pc [16]; logic ev [16]; logic [31:0] dat [16]; int rpc [16];
        drive_write(32'h204, 4'd0, 32'h0, 4'hF, -1, np, pc, ev);
        drive_write(32'h204, 4'd0, 32'h11223344, 4'b0011, -1, np, pc, ev);
        vecs++; if (np !== 1) begin errs++; $display("FAIL single_write_count: got %0d expected 1", np); end
        drive_read(32'h204, 4'd0, np, dat, rpc);
        vecs++; if (np !== 1) begin errs++; $display("FAIL single_read_count: got %0d expected 1", np); end
        vecs++; if (dat[0] !== 32'h00003344) begin errs++; $display("FAIL byte_enable_data: got %h expected 00003344", dat[0]); end
        vecs++; if (rpc[0] !== RL) begin errs++; $display("FAIL single_read_timing: got %0d expected %0d", rpc[0], RL); end
    endtask

    task automatic test_wrap();
        int np; int pc [16]; logic ev [16]; logic [31:0] dat [16]; int rpc [16];
        drive_write(32'h0000_1010, 4'd0, 32'hC0DE0001, 4'hF, -1, np, pc, ev);
        drive_read(32'h0000_0010, 4'd0, np, dat, rpc);
        vecs++; if (dat[0] !== 32'hC0DE0001) begin errs++; $display("FAIL wrap_low: got %h expected c0de0001", dat[0]); end
        drive_read(32'hFFFF_F010, 4'd0, np, dat, rpc);
        vecs++; if (dat[0] !== 32'hC0DE0001) begin errs++; $display("FAIL wrap_high: got %h expected c0de0001", dat[0]); end
    endtask

    task automatic test_concurrent();
        int np; int pc [16]; logic ev [16]; logic [31:0] dat [16]; int rpc [16];
        int rcyc, wcyc, cyc;
        logic [31:0] rd;
        drive_write(32'h300, 4'd0, 32'h5, 4'hF, -1, np, pc, ev);
        rcyc = -1; wcyc = -1; rd = '0;
        axi_raddr_i = 32'h300; axi_rlen_i = 4'd0;
        axi_ren_i = 1'b1; axi_rready_i = 1'b1; axi_ce_i = 1'b1;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                axi_waddr_i = 32'h300; axi_wdata_i = 32'h9; axi_sel_i = 4'hF; axi_wlen_i = 4'd0;
                axi_wlast_i = 1'b1; axi_wen_i = 1'b1; axi_wvalid_i = 1'b1;
            end
            if (rdata_valid_o) begin rcyc = cyc; rd = rdata_o; axi_ren_i = 1'b0; end
            if (wdata_resp_o) begin wcyc = cyc; axi_wen_i = 1'b0; axi_wvalid_i = 1'b0; end
            if (cyc >= 2) axi_ce_i = 1'b0;
        end
        axi_rready_i = 1'b0; axi_wlast_i = 1'b0;
        vecs++; if (rcyc !== RL) begin errs++; $display("FAIL conc_read_cycle: got %0d expected %0d", rcyc, RL); end
        vecs++; if (wcyc !== 1 + WL) begin errs++; $display("FAIL conc_write_cycle: got %0d expected %0d", wcyc, 1 + WL); end
        vecs++; if (rd !== 32'h5) begin errs++; $display("FAIL conc_old_data: got %h expected 00000005", rd); end
        drive_read(32'h300, 4'd0, np, dat, rpc);
        vecs++; if (dat[0] !== 32'h9) begin errs++; $display("FAIL conc_new_data: got %h expected 00000009", dat[0]); end
    endtask

    task automatic test_ren_abort();
        int cyc, np;
        np = 0;
        axi_raddr_i = 32'h100; axi_rlen_i = 4'd7;
        axi_ren_i = 1'b1; axi_rready_i = 1'b1; axi_ce_i = 1'b1;
        for (cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            axi_ce_i = 1'b0;
            if (rdata_valid_o) begin np++; axi_ren_i = 1'b0; axi_raddr_i = 32'h104; end
        end
        axi_rready_i = 1'b0;
        vecs++; if (np !== 1) begin errs++; $display("FAIL ren_abort_pulses: got %0d expected 1", np); end
    endtask

    task automatic test_wlast_error();
        int np; int pc [16]; logic ev [16];
        drive_write(32'h400, 4'd7, 32'hE0, 4'hF, 3, np, pc, ev);
        vecs++; if (np !== 8) begin errs++; $display("FAIL err_burst_count: got %0d expected 8", np); end
        vecs++; if (ev[2] !== 1'b0) begin errs++; $display("FAIL err_before_beat3: got %b expected 0", ev[2]); end
        vecs++; if (ev[3] !== 1'b1) begin errs++; $display("FAIL err_at_beat3: got %b expected 1", ev[3]); end
        vecs++; if (ev[7] !== 1'b1) begin errs++; $display("FAIL err_at_beat7: got %b expected 1", ev[7]); end
        repeat (5) @(posedge clk);
        #1;
        vecs++; if (err_o !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    endtask

    task automatic test_reset_midburst();
        int cyc, np, extra;
        logic [31:0] dat [16]; int rpc [16];
        np = 0; extra = 0;
        axi_raddr_i = 32'h100; axi_rlen_i = 4'd7;
        axi_ren_i = 1'b1; axi_rready_i = 1'b1; axi_ce_i = 1'b1;
        for (cyc = 1; cyc <= 60 && np < 4; cyc++) begin
            @(posedge clk); #1;
            axi_ce_i = 1'b0;
            if (rdata_valid_o) begin np++; axi_raddr_i = 32'h100 + 32'(4 * np); end
        end
        vecs++; if (np !== 4) begin errs++; $display("FAIL rst_pre_pulses: got %0d expected 4", np); end
        rst = 1'b0;
        #1;
        vecs++; if (rdata_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid_drop: got %b expected 0", rdata_valid_o); end
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h expected 0", rdata_o); end
        vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL rst_err_clear: got %b expected 0", err_o); end
        axi_ren_i = 1'b0; axi_rready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        for (cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (rdata_valid_o) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL rst_no_pulses: got %0d expected 0", extra); end
        drive_read(32'h100, 4'd7, np, dat, rpc);
        vecs++; if (np !== 8) begin errs++; $display("FAIL post_rst_count: got %0d expected 8", np); end
        vecs++; if (dat[0] !== 32'hA0) begin errs++; $display("FAIL post_rst_first: got %h expected 000000a0", dat[0]); end
        vecs++; if (dat[7] !== 32'hA7) begin errs++; $display("FAIL post_rst_last: got %h expected 000000a7", dat[7]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_byte_enable();
        test_wrap();
        test_concurrent();
        test_ren_abort();
        test_wlast_error();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
